// File: rtl/intpol2_dn_ctrl_if.sv
// intpol2_dn_ctrl_if
//   FIFO-side handshake bundle of the order-2 interpolator controller.
//   master : the controller (pops the input FIFO, pushes the output FIFO)
//   slave  : the FIFO pair / testbench side
//   Signals:
//     empty        input FIFO empty
//     afull        output FIFO almost full
//     read_enable  pop input FIFO
//     ld_data      output sample valid (combinational)
//     write_enable ld_data delayed one clock (registered)
interface intpol2_dn_ctrl_if;
  logic empty;
  logic afull;
  logic read_enable;
  logic ld_data;
  logic write_enable;

  modport master (
    input  empty,
    input  afull,
    output read_enable,
    output ld_data,
    output write_enable
  );

  modport slave (
    output empty,
    output afull,
    input  read_enable,
    input  ld_data,
    input  write_enable
  );
endinterface

// File: rtl/intpol2_dn_ctrl.sv
// intpol2_dn_ctrl
//   Control FSM for the order-2 interpolator datapath. Interpolation factor
//   D = 2^l2d (runtime, up to 2^L2D_MAX), NCH channels time-multiplexed per
//   input sample. Priming address, sub-sample and channel counters are
//   internal. Accelerator (one-shot) and stream modes, each with bypass.
//
//   Parameters: NCH (1..16), L2D_MAX, ADDR_W.
//   Ports:
//     clk, rstn          clock, asynchronous active-low reset
//     start              start / restart pulse
//     mode               1 = stream, 0 = accelerator
//     bypass             pass samples through without interpolation
//     l2d, n_prime       configuration, latched on start
//     fifo (master)      empty, afull in; read_enable, ld_data, write_enable out
//     busy, done, clear  status
//     en_m_addr, m_addr  priming address control
//     op_1, ld_p1_xi, sel_mult, en_sum, ch_sel, en_stream   datapath control
//     stop_empty, stop_afull   stall indicators
//   Optional: define INTPOL_STALL_CNT_EN to add stall_cnt[15:0], a saturating
//   count of stalled busy cycles, cleared by clear or reset.
module intpol2_dn_ctrl #(
  parameter int NCH     = 2,
  parameter int L2D_MAX = 4,
  parameter int ADDR_W  = 4,
  localparam int L2D_W  = $clog2(L2D_MAX + 1),
  localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              mode,
  input  logic              bypass,
  input  logic [L2D_W-1:0]  l2d,
  input  logic [ADDR_W-1:0] n_prime,
  intpol2_dn_ctrl_if.master fifo,
  output logic              busy,
  output logic              en_m_addr,
  output logic [ADDR_W-1:0] m_addr,
  output logic              op_1,
  output logic              ld_p1_xi,
  output logic              sel_mult,
  output logic              en_sum,
  output logic [CH_W-1:0]   ch_sel,
  output logic              en_stream,
  output logic              stop_empty,
  output logic              stop_afull,
  output logic              done,
  output logic              clear
`ifdef INTPOL_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLEAR,
    S_PRIME,
    S_OP1,
    S_LDP,
    S_CALC,
    S_CHNXT,
    S_DONE,
    S_STREAM,
    S_BYP_ACCEL,
    S_BYP_STRM
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] m_addr_reg;
  logic [L2D_MAX-1:0] sub_reg;
  logic [CH_W-1:0]   ch_reg;
  logic [L2D_W-1:0]  l2d_reg;
  logic [ADDR_W-1:0] n_prime_reg;
  logic              we_reg;

  logic [L2D_W-1:0]  l2d_clamped;
  logic [L2D_MAX:0]  d_val;
  logic [L2D_MAX:0]  d_m1;
  logic              sub_last;
  logic              prime_stall;
  logic              calc_stall;
  logic              prime_last;
  logic              ch_last;

  logic read_enable_c;
  logic ld_data_c;

  // Out-of-range l2d saturates to the largest supported factor.
  assign l2d_clamped = (l2d > L2D_W'(L2D_MAX)) ? L2D_W'(L2D_MAX) : l2d;

  // One extra bit so that D = 2^L2D_MAX is representable before the -1.
  assign d_val    = (L2D_MAX + 1)'(1) << l2d_reg;
  assign d_m1     = d_val - (L2D_MAX + 1)'(1);
  assign sub_last = ({1'b0, sub_reg} == d_m1);

  // Stalls only apply in stream mode; accelerator mode assumes data is ready.
  assign prime_stall = mode & fifo.empty;
  assign calc_stall  = mode & fifo.afull;
  assign prime_last  = (m_addr_reg == n_prime_reg);
  assign ch_last     = (ch_reg == CH_W'(NCH - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= S_IDLE;
      m_addr_reg  <= '0;
      sub_reg     <= '0;
      ch_reg      <= '0;
      l2d_reg     <= '0;
      n_prime_reg <= '0;
      we_reg      <= 1'b0;
    end else begin
      we_reg <= ld_data_c;
      if (start && (state != S_IDLE)) begin
        // Restart wins over every other transition.
        state       <= S_CLEAR;
        m_addr_reg  <= '0;
        sub_reg     <= '0;
        ch_reg      <= '0;
        l2d_reg     <= l2d_clamped;
        n_prime_reg <= n_prime;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              l2d_reg     <= l2d_clamped;
              n_prime_reg <= n_prime;
              m_addr_reg  <= '0;
              sub_reg     <= '0;
              ch_reg      <= '0;
              state       <= (bypass && mode) ? S_BYP_STRM : S_PRIME;
            end
          end
          S_CLEAR: begin
            if (!prime_stall) state <= S_PRIME;
          end
          S_PRIME: begin
            if (!prime_stall) begin
              if (prime_last) begin
                m_addr_reg <= '0;
                ch_reg     <= '0;
                if (bypass) state <= mode ? S_BYP_STRM : S_BYP_ACCEL;
                else        state <= S_OP1;
              end else begin
                m_addr_reg <= m_addr_reg + 1'b1;
              end
            end
          end
          S_OP1: state <= S_LDP;
          S_LDP: state <= S_CALC;
          S_CALC: begin
            if (!calc_stall) begin
              if (sub_last) begin
                sub_reg <= '0;
                state   <= S_CHNXT;
              end else begin
                sub_reg <= sub_reg + 1'b1;
                state   <= S_LDP;
              end
            end
          end
          S_CHNXT: begin
            if (ch_last) begin
              ch_reg <= '0;
              state  <= S_DONE;
            end else begin
              // Next channel reuses the same input sample.
              ch_reg <= ch_reg + 1'b1;
              state  <= S_OP1;
            end
          end
          S_DONE:      state <= mode ? S_STREAM : S_IDLE;
          S_STREAM:    if (!fifo.empty) state <= S_OP1;
          S_BYP_ACCEL: state <= S_IDLE;
          S_BYP_STRM:  state <= S_BYP_STRM;
          default:     state <= S_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    read_enable_c = 1'b0;
    ld_data_c     = 1'b0;
    en_m_addr     = 1'b0;
    op_1          = 1'b0;
    ld_p1_xi      = 1'b0;
    sel_mult      = 1'b0;
    en_sum        = 1'b0;
    en_stream     = 1'b0;
    stop_empty    = 1'b0;
    stop_afull    = 1'b0;
    done          = 1'b0;
    case (state)
      S_CLEAR: stop_empty = prime_stall;
      S_PRIME: begin
        read_enable_c = 1'b1;
        if (prime_stall) stop_empty = 1'b1;
        else             en_m_addr  = 1'b1;
      end
      S_OP1: op_1     = 1'b1;
      S_LDP: ld_p1_xi = 1'b1;
      S_CALC: begin
        sel_mult = 1'b1;
        // afull takes precedence: empty is irrelevant while computing.
        if (calc_stall) begin
          stop_afull = 1'b1;
        end else begin
          ld_data_c = 1'b1;
          en_sum    = !sub_last;
        end
      end
      S_DONE: done = 1'b1;
      S_STREAM: begin
        read_enable_c = 1'b1;
        en_stream     = 1'b1;
        stop_empty    = 1'b1;
      end
      S_BYP_ACCEL: done = 1'b1;
      S_BYP_STRM: begin
        read_enable_c = !fifo.empty;
        stop_empty    = fifo.empty;
        stop_afull    = fifo.afull;
        ld_data_c     = !fifo.empty && !fifo.afull;
      end
      default: ;
    endcase
  end

  assign busy              = (state != S_IDLE);
  assign clear             = start | done;
  assign m_addr            = m_addr_reg;
  assign ch_sel            = ch_reg;
  assign fifo.read_enable  = read_enable_c;
  assign fifo.ld_data      = ld_data_c;
  assign fifo.write_enable = we_reg;

`ifdef INTPOL_STALL_CNT_EN
  logic [15:0] stall_cnt_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt_reg <= '0;
    end else if (clear) begin
      stall_cnt_reg <= '0;
    end else if (busy && (stop_empty || stop_afull) && (stall_cnt_reg != 16'hFFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_intpol2_dn_ctrl.sv
// tb_intpol2_dn_ctrl
//   Directed bench for intpol2_dn_ctrl (NCH=2, L2D_MAX=4, ADDR_W=4).
//   Each scenario drives start/empty/afull from per-cycle bit masks for a
//   window of cycles after a reset, records every control output as a
//   per-cycle bit mask, and compares against hand-derived masks.
module tb_intpol2_dn_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic       start;
  logic       mode;
  logic       bypass;
  logic [2:0] l2d;
  logic [3:0] n_prime;

  logic       busy, en_m_addr, op_1, ld_p1_xi, sel_mult, en_sum;
  logic       en_stream, stop_empty, stop_afull, done, clear;
  logic [3:0] m_addr;
  logic [0:0] ch_sel;

  intpol2_dn_ctrl_if bus ();

  intpol2_dn_ctrl #(.NCH(2), .L2D_MAX(4), .ADDR_W(4)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .mode       (mode),
    .bypass     (bypass),
    .l2d        (l2d),
    .n_prime    (n_prime),
    .fifo       (bus),
    .busy       (busy),
    .en_m_addr  (en_m_addr),
    .m_addr     (m_addr),
    .op_1       (op_1),
    .ld_p1_xi   (ld_p1_xi),
    .sel_mult   (sel_mult),
    .en_sum     (en_sum),
    .ch_sel     (ch_sel),
    .en_stream  (en_stream),
    .stop_empty (stop_empty),
    .stop_afull (stop_afull),
    .done       (done),
    .clear      (clear)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Stimulus masks: bit t applies during capture cycle t.
  logic [63:0] start_mask, empty_mask, afull_mask;
  int          rst_t, l2d_sw_t;
  logic [2:0]  l2d_sw_val;

  // Observation masks: bit t = output value in capture cycle t.
  logic [63:0] o_busy, o_en_m, o_op1, o_ldp, o_sel, o_sum, o_stream;
  logic [63:0] o_se, o_sa, o_done, o_clear, o_re, o_ld, o_we, o_ch;
  logic [3:0]  maddr_log [64];
  logic [0:0]  ch_log [64];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  task automatic do_reset();
    rstn       = 1'b0;
    start      = 1'b0;
    bus.empty  = 1'b0;
    bus.afull  = 1'b0;
    start_mask = 64'h1;
    empty_mask = '0;
    afull_mask = '0;
    rst_t      = -1;
    l2d_sw_t   = -1;
    l2d_sw_val = '0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_capture(input int ncyc);
    o_busy = '0; o_en_m = '0; o_op1 = '0; o_ldp = '0; o_sel = '0; o_sum = '0;
    o_stream = '0; o_se = '0; o_sa = '0; o_done = '0; o_clear = '0; o_re = '0;
    o_ld = '0; o_we = '0; o_ch = '0;
    for (int t = 0; t < ncyc; t++) begin
      @(negedge clk);
      start     = start_mask[t];
      bus.empty = empty_mask[t];
      bus.afull = afull_mask[t];
      if (t == l2d_sw_t) l2d = l2d_sw_val;
      if (t == rst_t) rstn = 1'b0;
      #1;
      o_busy[t]   = busy;
      o_en_m[t]   = en_m_addr;
      o_op1[t]    = op_1;
      o_ldp[t]    = ld_p1_xi;
      o_sel[t]    = sel_mult;
      o_sum[t]    = en_sum;
      o_stream[t] = en_stream;
      o_se[t]     = stop_empty;
      o_sa[t]     = stop_afull;
      o_done[t]   = done;
      o_clear[t]  = clear;
      o_re[t]     = bus.read_enable;
      o_ld[t]     = bus.ld_data;
      o_we[t]     = bus.write_enable;
      o_ch[t]     = bus.ld_data & ch_sel[0];
      maddr_log[t] = m_addr;
      ch_log[t]    = ch_sel;
    end
    start     = 1'b0;
    bus.empty = 1'b0;
    bus.afull = 1'b0;
  endtask

  initial begin
    mode = 1'b0; bypass = 1'b0; l2d = 3'd2; n_prime = 4'd3;
    do_reset();

    // Reset state.
    #1;
    chk("rst_busy",  {63'd0, busy}, 64'd0);
    chk("rst_we",    {63'd0, bus.write_enable}, 64'd0);
    chk("rst_maddr", {60'd0, m_addr}, 64'd0);
    chk("rst_ctl",   {57'd0, bus.ld_data, bus.read_enable, done, clear, op_1, en_m_addr, ch_sel}, 64'd0);

    // Accelerator, l2d=2, n_prime=3.
    mode = 1'b0; bypass = 1'b0; l2d = 3'd2; n_prime = 4'd3;
    do_reset();
    run_capture(32);
    chk("acc_en_m",  o_en_m, 64'h1E);
    chk("acc_maddr", {48'd0, maddr_log[1], maddr_log[2], maddr_log[3], maddr_log[4]}, 64'h0123);
    chk("acc_op1",   o_op1, 64'h8020);
    chk("acc_ldp",   o_ldp, 64'h551540);
    chk("acc_ld",    o_ld, 64'hAA2A80);
    chk("acc_ch",    o_ch, 64'hAA0000);
    chk("acc_we",    o_we, 64'h1545500);
    chk("acc_done",  o_done, 64'h2000000);
    chk("acc_clear", o_clear, 64'h2000001);
    chk("acc_busy",  o_busy, 64'h3FFFFFE);

    // Stream, l2d=3, afull for 5 CALC cycles, then empty for 4 cycles after DONE.
    mode = 1'b1; bypass = 1'b0; l2d = 3'd3; n_prime = 4'd1;
    do_reset();
    afull_mask = 64'h3E0;
    empty_mask = 64'h0001E000_00000000;
    run_capture(64);
    chk("str_afull",  o_sa, 64'h3E0);
    chk("str_ld",     o_ld, 64'h55500555_51555400);
    chk("str_ch",     o_ch, 64'h00000555_50000000);
    chk("str_sel",    o_sel, 64'h55500555_515557E0);
    chk("str_sum",    o_sum, 64'h55500155_50555400);
    chk("str_done",   o_done, 64'h00001000_00000000);
    chk("str_empty",  o_se, 64'h0003E000_00000000);
    chk("str_enstr",  o_stream, 64'h0003E000_00000000);
    chk("str_op1",    o_op1, 64'h00040000_04000008);

    // Restart mid-CALC on channel 1, relatching l2d=0 (D=1).
    mode = 1'b0; bypass = 1'b0; l2d = 3'd1; n_prime = 4'd1;
    do_reset();
    start_mask = 64'h1801;
    l2d_sw_t   = 11;
    l2d_sw_val = 3'd0;
    run_capture(32);
    chk("rs_clear", o_clear, 64'h1001801);
    chk("rs_ch12",  {63'd0, ch_log[12]}, 64'd0);
    chk("rs_en_m",  o_en_m, 64'hC006);
    chk("rs_maddr", {56'd0, maddr_log[14], maddr_log[15]}, 64'h01);
    chk("rs_ld",    o_ld, 64'h4408A0);
    chk("rs_ch",    o_ch, 64'h400800);
    chk("rs_we",    o_we, 64'h881140);
    chk("rs_sum",   o_sum, 64'h820);
    chk("rs_op1",   o_op1, 64'h110208);
    chk("rs_done",  o_done, 64'h1000000);
    chk("rs_busy",  o_busy, 64'h1FFFFFE);

    // Out-of-range l2d=7 clamps to 4: 16 pulses on channel 0 before channel 1.
    mode = 1'b0; bypass = 1'b0; l2d = 3'd7; n_prime = 4'd0;
    do_reset();
    run_capture(40);
    chk("clamp_cnt", 64'($countones(o_ld[35:0])), 64'd16);
    chk("clamp_op1", {63'd0, o_op1[36]}, 64'd1);

    // Bypass accelerator.
    mode = 1'b0; bypass = 1'b1; l2d = 3'd2; n_prime = 4'd2;
    do_reset();
    run_capture(16);
    chk("ba_en_m",  o_en_m, 64'hE);
    chk("ba_done",  o_done, 64'h10);
    chk("ba_busy",  o_busy, 64'h1E);
    chk("ba_clear", o_clear, 64'h11);
    chk("ba_op_ld", o_op1 | o_ld, 64'd0);

    // Bypass stream with reset asserted at cycle 14.
    mode = 1'b1; bypass = 1'b1; l2d = 3'd2; n_prime = 4'd2;
    do_reset();
    empty_mask = 64'h118;
    afull_mask = 64'h650;
    rst_t      = 14;
    run_capture(16);
    rstn = 1'b1;
    chk("bs_ld",    o_ld, 64'h38A6);
    chk("bs_we",    o_we, 64'h314C);
    chk("bs_se",    o_se, 64'h118);
    chk("bs_sa",    o_sa, 64'h650);
    chk("bs_re",    o_re, 64'h3EE6);
    chk("bs_busy",  o_busy, 64'h3FFE);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
